// File: rtl/perf_event_counters.sv
// Per-core performance counters: NUM_EVT event channels plus a cycle counter, an IDLE/RUN/FROZEN
// control FSM and a one-cycle registered read port. Define PERF_SATURATE_EN for saturating counters.
module perf_event_counters #(
    parameter int NUM_EVT   = 6,
    parameter int CNT_W     = 32,
    parameter int RD_ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_EVT-1:0]   evt,
    input  logic                 count_en,
    input  logic                 clr,
    input  logic                 halt,
    input  logic                 rd_req,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic                 rd_ack,
    output logic [CNT_W-1:0]     rd_data,
    output logic                 rd_err,
    output logic                 frozen,
    output logic                 running,
    output logic [NUM_EVT:0]     ovf
);

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    localparam logic [RD_ADDR_W-1:0] CYC_ADDR = RD_ADDR_W'(NUM_EVT);

    state_t           state, nextState;
    logic [CNT_W-1:0] cnt [NUM_EVT+1];
    logic [NUM_EVT:0] ovfReg;
    logic [NUM_EVT:0] incVec;
    logic [CNT_W-1:0] rdMux;
    logic             addrBad;
    logic             ackP1;
    logic             errP1;
    logic [CNT_W-1:0] dataP1;

    function automatic logic [CNT_W-1:0] bumpCount(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
        return (v == '1) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (count_en) nextState = RUN;
            RUN: begin
                if (halt)           nextState = FROZEN;
                else if (!count_en) nextState = IDLE;
            end
            FROZEN:  nextState = FROZEN;
            default: nextState = IDLE;
        endcase
        if (clr) nextState = IDLE;
    end

    // Top bit is the cycle counter, which ticks on every RUN cycle.
    assign incVec = (state == RUN) ? {1'b1, evt} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfReg <= '0;
            for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
        end else if (clr) begin
            ovfReg <= '0;
            for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                if (incVec[i]) begin
                    cnt[i] <= bumpCount(cnt[i]);
                    if (cnt[i] == '1) ovfReg[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i <= NUM_EVT; i++)
            if (rd_addr == RD_ADDR_W'(i)) rdMux = cnt[i];
    end

    assign addrBad = (rd_addr > CYC_ADDR);

    // Read stage p1: samples pre-update counter values, data holds between requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackP1  <= 1'b0;
            errP1  <= 1'b0;
            dataP1 <= '0;
        end else begin
            ackP1 <= rd_req;
            errP1 <= rd_req && addrBad;
            if (rd_req) dataP1 <= rdMux;
        end
    end

    assign rd_ack  = ackP1;
    assign rd_err  = errP1;
    assign rd_data = dataP1;
    assign ovf     = ovfReg;
    assign frozen  = (state == FROZEN);
    assign running = (state == RUN);

endmodule
